// File: rtl/timer_display_mux.sv
// Eight-digit multiplexed 7-segment driver for the countdown timer (HH.MM.SS.hh).
// Ports: clk, reset (sync, active-high); hour/minute/second/hundredth [6:0] binary
// fields; done_signal level; seg[6:0] (a..g), dp, an[7:0] all active-low, registered.
// Optional macro BLINK_ON_DONE_EN: blank the anodes at BLINK_DIV half-period while
// done_signal is high; when undefined, done_signal is ignored and the display never blanks.
module timer_display_mux #(
  parameter int REFRESH_DIV = 125000,
  parameter int BLINK_DIV   = 31250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hour,
  input  logic [6:0] minute,
  input  logic [6:0] second,
  input  logic [6:0] hundredth,
  input  logic       done_signal,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] r_refresh;
  logic [2:0]    r_digit;
  logic [6:0]    r_snap_h;
  logic [6:0]    r_snap_m;
  logic [6:0]    r_snap_s;
  logic [6:0]    r_snap_hh;

  logic          w_slot_wrap;
  logic          w_frame_wrap;
  logic [6:0]    w_field;
  logic [6:0]    w_sat;
  logic [3:0]    w_bcd;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic [7:0]    w_an;
  logic          w_blank;

  assign w_slot_wrap  = (r_refresh == RW'(REFRESH_DIV - 1));
  assign w_frame_wrap = w_slot_wrap && (r_digit == 3'd7);

  // Slot timing and frame-start snapshot; all digits of a frame read
  // the snapshot so a field never tears mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_digit   <= 3'd0;
      r_snap_h  <= 7'd0;
      r_snap_m  <= 7'd0;
      r_snap_s  <= 7'd0;
      r_snap_hh <= 7'd0;
    end else begin
      if (w_slot_wrap) begin
        r_refresh <= '0;
        r_digit   <= r_digit + 3'd1;
      end else begin
        r_refresh <= r_refresh + RW'(1);
      end
      if (w_frame_wrap) begin
        r_snap_h  <= hour;
        r_snap_m  <= minute;
        r_snap_s  <= second;
        r_snap_hh <= hundredth;
      end
    end
  end

  // Digit pairs: 7,6 hour; 5,4 minute; 3,2 second; 1,0 hundredth.
  always_comb begin
    w_field = r_snap_hh;
    case (r_digit[2:1])
      2'd3:    w_field = r_snap_h;
      2'd2:    w_field = r_snap_m;
      2'd1:    w_field = r_snap_s;
      default: w_field = r_snap_hh;
    endcase
  end

  assign w_sat = (w_field > 7'd99) ? 7'd99 : w_field;
  assign w_bcd = r_digit[0] ? 4'(w_sat / 7'd10) : 4'(w_sat % 7'd10);

  always_comb begin
    w_seg = 7'h7F;
    case (w_bcd)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end

  // Separators after hour, minute and second ones digits.
  assign w_dp = ~(~r_digit[0] && (r_digit != 3'd0));
  assign w_an = ~(8'd1 << r_digit);

`ifdef BLINK_ON_DONE_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  // Counter idles at 0 while done is low so a rising done starts in
  // the on phase.
  always_ff @(posedge clk) begin
    if (reset || !done_signal) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Gated by the live done level so a falling done unblanks at once.
  assign w_blank = done_signal & r_blink_phase;
`else
  logic w_unused;
  assign w_unused = done_signal ^ (BLINK_DIV == 0);
  assign w_blank  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= w_blank ? 8'hFF : w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule

// File: tb/tb_timer_display_mux.sv
// Randomised bench for timer_display_mux against a frame-level reference model.
// Directed literal checks pin the model; one process compares every cycle.
module tb_timer_display_mux;

  localparam int RD = 4;
  localparam int BD = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] hour, minute, second, hundredth;
  logic       done_signal;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  int checks = 0;
  int failures = 0;

  timer_display_mux #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .hour(hour), .minute(minute), .second(second), .hundredth(hundredth),
    .done_signal(done_signal),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Model: n = edges since reset release. Output after edge n shows slot
  // (n-1)/RD of its frame; the frame snapshot is taken at every 8*RD-th edge.
  int         n = 0;
  int         m = 0;
  int         snap [4];
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  bit         m_valid = 0;

  always @(posedge clk) begin
    int  d, v;
    bit  blank;
    if (reset) begin
      n = 0;
      m = 0;
      foreach (snap[k]) snap[k] = 0;
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      n++;
      d = ((n - 1) / RD) % 8;
      v = snap[d / 2];
      if (v > 99) v = 99;
      v = (d % 2 == 1) ? v / 10 : v % 10;
      e_seg = seg_of(v);
      e_dp  = !(d == 2 || d == 4 || d == 6);
      blank = 0;
`ifdef BLINK_ON_DONE_EN
      if (done_signal) begin
        blank = ((m / BD) % 2) == 1;
        m++;
      end else begin
        m = 0;
      end
`endif
      e_an = blank ? 8'hFF : ~(8'd1 << d);
      if (n % (8 * RD) == 0) begin
        snap[0] = int'(hundredth);
        snap[1] = int'(second);
        snap[2] = int'(minute);
        snap[3] = int'(hour);
      end
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        failures++;
        $display("FAIL scan n=%0d actual an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 n, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  end

  task automatic lit(input string nm, input logic [7:0] a,
                     input logic [6:0] s, input logic d);
    @(negedge clk);
    checks++;
    if (an !== a || seg !== s || dp !== d) begin
      failures++;
      $display("FAIL %s actual an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
               nm, an, seg, dp, a, s, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    done_signal = 1'b0;
    hour = 7'd0; minute = 7'd0; second = 7'd0; hundredth = 7'd0;
    repeat (2) @(posedge clk);
    lit("reset_state", 8'hFF, 7'h7F, 1'b1);

    @(posedge clk); #1;
    reset = 1'b0;
    hour = 7'd1; minute = 7'd23; second = 7'd45; hundredth = 7'd67;

    @(posedge clk);
    lit("first_digit_zero", 8'hFE, 7'h40, 1'b1);        // edge 1
    repeat (32) @(posedge clk);
    lit("hh_ones_7", 8'hFE, 7'h78, 1'b1);               // edge 33
    repeat (12) @(posedge clk);
    lit("sec_tens_4", 8'hF7, 7'h19, 1'b1);              // edge 45
    minute = 7'd24;
    repeat (4) @(posedge clk);
    lit("min_ones_still_3", 8'hEF, 7'h30, 1'b0);        // edge 49
    repeat (8) @(posedge clk);
    lit("hour_ones_1", 8'hBF, 7'h79, 1'b0);             // edge 57
    repeat (24) @(posedge clk);
    lit("min_ones_now_4", 8'hEF, 7'h19, 1'b0);          // edge 81
    hour = 7'd120; second = 7'd100;
    repeat (28) @(posedge clk);
    lit("sec_tens_sat_9", 8'hF7, 7'h10, 1'b1);          // edge 109
    repeat (16) @(posedge clk);
    lit("hour_tens_sat_9", 8'h7F, 7'h10, 1'b1);         // edge 125
    repeat (25) @(posedge clk);                         // edge 150, digit 5
    reset = 1'b1;
    lit("mid_frame_reset", 8'hFF, 7'h7F, 1'b1);
    reset = 1'b0;
    lit("post_reset_zero", 8'hFE, 7'h40, 1'b1);

    done_signal = 1'b1;
    repeat (65) @(posedge clk);
    @(negedge clk);
`ifdef BLINK_ON_DONE_EN
    checks++;
    if (an !== 8'hFF) begin
      failures++;
      $display("FAIL blink_off actual an=%h required an=ff", an);
    end
`endif
    repeat (191) @(posedge clk);
    @(negedge clk);
    done_signal = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 19) == 0) hour = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) minute = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) second = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) hundredth = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 199) == 0) done_signal = ~done_signal;
      reset = ($urandom_range(0, 599) == 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
